// File: rtl/maze_pkg.sv
// Shared maze geometry, loader state encoding and ROM base-address helper.
// Used by the maze loader and the VGA maze slave.
`default_nettype none

package maze_pkg;

  localparam int NUM_WORDS     = 600;
  localparam int NUM_MAZES     = 4;
  localparam int SEL_W         = 2;
  localparam int ROM_AW        = 12;
  localparam int WORDS_PER_ROW = 5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ROMWAIT = 3'd2,
    S_WRITE   = 3'd3,
    S_FINISH  = 3'd4
  } loader_state_t;

  function automatic logic [ROM_AW-1:0] maze_base(input logic [SEL_W-1:0] sel);
    return ROM_AW'(sel) * ROM_AW'(NUM_WORDS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/maze_loader_avl_master.sv
// /*------------------------------------------------------------------------
//  * maze_loader_avl_master: Avalon-MM write master that copies a maze from
//  * ROM (or zero-fills) into the slave's maze word file.  Rev 1.0
//  *----------------------------------------------------------------------*/
`default_nettype none

module maze_loader_avl_master #(
  parameter int NUM_WORDS = maze_pkg::NUM_WORDS,
  parameter int NUM_MAZES = maze_pkg::NUM_MAZES,
  parameter int SEL_W     = maze_pkg::SEL_W,
  parameter int ROM_AW    = maze_pkg::ROM_AW
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              CLEAR,
  input  logic [SEL_W-1:0]  MAZE_SEL,
  output logic              BUSY,
  output logic              DONE,
  output logic [9:0]        WORD_COUNT,
  output logic [ROM_AW-1:0] ROM_ADDR,
  input  logic [31:0]       ROM_RDDATA,
  output logic [9:0]        AVL_ADDR,
  output logic              AVL_WRITE,
  output logic              AVL_CS,
  output logic [3:0]        AVL_BYTE_EN,
  output logic [31:0]       AVL_WRITEDATA,
  input  logic              AVL_WAITREQUEST
);

  import maze_pkg::*;

  loader_state_t     state;
  logic [ROM_AW-1:0] base;
  logic [9:0]        idx;
  logic              clear_mode;

  logic              sel_out_of_range;
  logic              start_clear;
  logic              last_word;
  logic [ROM_AW-1:0] sel_base;

  assign sel_out_of_range = (32'(MAZE_SEL) >= NUM_MAZES);
  assign start_clear      = CLEAR | sel_out_of_range;
  assign last_word        = (idx == 10'(NUM_WORDS - 1));
  assign sel_base         = ROM_AW'(MAZE_SEL) * ROM_AW'(NUM_WORDS);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= S_IDLE;
      base          <= '0;
      idx           <= '0;
      clear_mode    <= 1'b0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      WORD_COUNT    <= '0;
      ROM_ADDR      <= '0;
      AVL_ADDR      <= '0;
      AVL_WRITE     <= 1'b0;
      AVL_CS        <= 1'b0;
      AVL_BYTE_EN   <= 4'h0;
      AVL_WRITEDATA <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          DONE <= 1'b0;
          // DONE is still high in the first IDLE cycle; a START there is ignored.
          if (START && !DONE) begin
            clear_mode <= start_clear;
            base       <= sel_base;
            idx        <= '0;
            BUSY       <= 1'b1;
            WORD_COUNT <= '0;
            if (start_clear) begin
              AVL_WRITEDATA <= '0;
              AVL_ADDR      <= '0;
              AVL_WRITE     <= 1'b1;
              AVL_CS        <= 1'b1;
              AVL_BYTE_EN   <= 4'hF;
              state         <= S_WRITE;
            end else begin
              state <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          ROM_ADDR <= base + ROM_AW'(idx);
          state    <= S_ROMWAIT;
        end

        S_ROMWAIT: begin
          AVL_WRITEDATA <= ROM_RDDATA;
          AVL_ADDR      <= idx;
          AVL_WRITE     <= 1'b1;
          AVL_CS        <= 1'b1;
          AVL_BYTE_EN   <= 4'hF;
          state         <= S_WRITE;
        end

        S_WRITE: begin
          if (!AVL_WAITREQUEST) begin
            WORD_COUNT <= WORD_COUNT + 10'd1;
            if (last_word) begin
              AVL_WRITE   <= 1'b0;
              AVL_CS      <= 1'b0;
              AVL_BYTE_EN <= 4'h0;
              state       <= S_FINISH;
            end else begin
              idx <= idx + 10'd1;
              if (clear_mode) begin
                AVL_ADDR <= idx + 10'd1;
              end else begin
                AVL_WRITE   <= 1'b0;
                AVL_CS      <= 1'b0;
                AVL_BYTE_EN <= 4'h0;
                state       <= S_FETCH;
              end
            end
          end
        end

        S_FINISH: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
